// File: rtl/video_frame_probe.sv
// video_frame_probe: measures each video frame (width, height, lit pixels,
// luma sum, line-width consistency) and publishes one result per frame
// through a valid/ready register interface.
module video_frame_probe #(
  parameter int unsigned       COLSPC = 10,
  parameter int unsigned       CNTW   = 12,
  parameter int unsigned       LITW   = 24,
  parameter int unsigned       SUMW   = 32,
  parameter logic [COLSPC-1:0] THRESH = COLSPC'(128)
) (
  input  logic              video_clk_pix,
  input  logic              rst,
  input  logic              video_enable,
  input  logic              frame_start,
  input  logic              line_start,
  input  logic [COLSPC-1:0] red,
  input  logic [COLSPC-1:0] green,
  input  logic [COLSPC-1:0] blue,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [CNTW-1:0]   res_width,
  output logic [CNTW-1:0]   res_height,
  output logic [LITW-1:0]   res_lit,
  output logic [SUMW-1:0]   res_luma,
  output logic              res_mismatch,
  output logic [7:0]        res_dropped
);

  localparam int unsigned LUMAW = COLSPC + 2;
  localparam int unsigned SUMW1 = SUMW + 1;

  localparam logic [0:0] S_IDLE    = 1'b0;
  localparam logic [0:0] S_MEASURE = 1'b1;

  logic [0:0]      r_state,   w_state_nxt;
  logic [CNTW-1:0] r_lpx,     w_lpx_nxt;
  logic [CNTW-1:0] r_width,   w_width_nxt;
  logic [CNTW-1:0] r_height,  w_height_nxt;
  logic            r_have_w,  w_have_w_nxt;
  logic            r_mismatch, w_mismatch_nxt;
  logic [LITW-1:0] r_lit,     w_lit_nxt;
  logic [SUMW-1:0] r_luma,    w_luma_nxt;
  logic            w_publish;

  // Per-pixel luma and lit decision
  logic [LUMAW-1:0]  w_luma_full;
  logic [COLSPC-1:0] w_luma;
  logic              w_lit;
  assign w_luma_full = LUMAW'(red) + (LUMAW'(green) << 1) + LUMAW'(blue);
  assign w_luma      = COLSPC'(w_luma_full >> 2);
  assign w_lit       = (red >= THRESH) || (green >= THRESH) || (blue >= THRESH);

  // Saturating increments / accumulation
  logic [CNTW-1:0]  w_lpx_inc, w_height_inc;
  logic [LITW-1:0]  w_lit_inc;
  logic [SUMW1-1:0] w_luma_sum;
  logic [SUMW-1:0]  w_luma_add;
  assign w_lpx_inc    = (&r_lpx)    ? r_lpx    : r_lpx + CNTW'(1);
  assign w_height_inc = (&r_height) ? r_height : r_height + CNTW'(1);
  assign w_lit_inc    = (&r_lit)    ? r_lit    : r_lit + LITW'(1);
  assign w_luma_sum   = {1'b0, r_luma} + SUMW1'(w_luma);
  assign w_luma_add   = w_luma_sum[SUMW] ? {SUMW{1'b1}} : w_luma_sum[SUMW-1:0];

  // Line close: statistics including the line that ends this cycle
  logic            w_close;
  logic [CNTW-1:0] w_cl_height, w_cl_width;
  logic            w_cl_have_w, w_cl_mismatch;
  assign w_close       = (frame_start || line_start) && (r_lpx != '0);
  assign w_cl_height   = w_close ? w_height_inc : r_height;
  assign w_cl_width    = (w_close && !r_have_w) ? r_lpx : r_width;
  assign w_cl_have_w   = r_have_w || w_close;
  assign w_cl_mismatch = r_mismatch || (w_close && r_have_w && (r_lpx != r_width));

  // Accumulator seeds when the sampled pixel opens a new line/frame
  logic [CNTW-1:0] w_new_lpx;
  logic [LITW-1:0] w_new_lit;
  logic [SUMW-1:0] w_new_luma;
  assign w_new_lpx  = video_enable ? CNTW'(1) : '0;
  assign w_new_lit  = (video_enable && w_lit) ? LITW'(1) : '0;
  assign w_new_luma = video_enable ? SUMW'(w_luma) : '0;

  // State register and accumulators
  always_ff @(posedge video_clk_pix or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_lpx      <= '0;
      r_width    <= '0;
      r_height   <= '0;
      r_have_w   <= 1'b0;
      r_mismatch <= 1'b0;
      r_lit      <= '0;
      r_luma     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_lpx      <= w_lpx_nxt;
      r_width    <= w_width_nxt;
      r_height   <= w_height_nxt;
      r_have_w   <= w_have_w_nxt;
      r_mismatch <= w_mismatch_nxt;
      r_lit      <= w_lit_nxt;
      r_luma     <= w_luma_nxt;
    end
  end

  // Next-state and accumulator update
  always_comb begin
    w_state_nxt    = r_state;
    w_lpx_nxt      = r_lpx;
    w_width_nxt    = r_width;
    w_height_nxt   = r_height;
    w_have_w_nxt   = r_have_w;
    w_mismatch_nxt = r_mismatch;
    w_lit_nxt      = r_lit;
    w_luma_nxt     = r_luma;
    w_publish      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (frame_start) begin
          w_state_nxt    = S_MEASURE;
          w_lpx_nxt      = w_new_lpx;
          w_width_nxt    = '0;
          w_height_nxt   = '0;
          w_have_w_nxt   = 1'b0;
          w_mismatch_nxt = 1'b0;
          w_lit_nxt      = w_new_lit;
          w_luma_nxt     = w_new_luma;
        end
      end
      S_MEASURE: begin
        if (frame_start) begin
          w_publish      = 1'b1;
          w_lpx_nxt      = w_new_lpx;
          w_width_nxt    = '0;
          w_height_nxt   = '0;
          w_have_w_nxt   = 1'b0;
          w_mismatch_nxt = 1'b0;
          w_lit_nxt      = w_new_lit;
          w_luma_nxt     = w_new_luma;
        end else begin
          w_height_nxt   = w_cl_height;
          w_width_nxt    = w_cl_width;
          w_have_w_nxt   = w_cl_have_w;
          w_mismatch_nxt = w_cl_mismatch;
          if (line_start) begin
            w_lpx_nxt = w_new_lpx;
          end else if (video_enable) begin
            w_lpx_nxt = w_lpx_inc;
          end
          if (video_enable) begin
            w_luma_nxt = w_luma_add;
            if (w_lit) begin
              w_lit_nxt = w_lit_inc;
            end
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Result registers with valid/ready handshake and drop counter
  always_ff @(posedge video_clk_pix or posedge rst) begin
    if (rst) begin
      res_valid    <= 1'b0;
      res_width    <= '0;
      res_height   <= '0;
      res_lit      <= '0;
      res_luma     <= '0;
      res_mismatch <= 1'b0;
      res_dropped  <= '0;
    end else if (w_publish) begin
      res_valid    <= 1'b1;
      res_width    <= w_cl_width;
      res_height   <= w_cl_height;
      res_lit      <= r_lit;
      res_luma     <= r_luma;
      res_mismatch <= w_cl_mismatch;
      if (res_valid && !res_ready && !(&res_dropped)) begin
        res_dropped <= res_dropped + 8'd1;
      end
    end else if (res_valid && res_ready) begin
      res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_video_frame_probe.sv
// Scoreboard bench for video_frame_probe: a default instance and a CNTW=4
// instance share randomized frame stimulus; a frame-level model predicts
// each published result and a negedge monitor checks on acceptance.
module tb_video_frame_probe;

  logic       clk = 1'b0;
  logic       rst;
  logic       video_enable, frame_start, line_start, res_ready;
  logic [9:0] red, green, blue;

  logic        va, ma, vb, mb;
  logic [11:0] wa, ha;
  logic [3:0]  wb, hb;
  logic [23:0] la, lb;
  logic [31:0] sa, sb;
  logic [7:0]  da, db;

  always #5 clk = ~clk;

  video_frame_probe u_dut (
    .video_clk_pix(clk), .rst(rst), .video_enable(video_enable),
    .frame_start(frame_start), .line_start(line_start),
    .red(red), .green(green), .blue(blue),
    .res_valid(va), .res_ready(res_ready), .res_width(wa), .res_height(ha),
    .res_lit(la), .res_luma(sa), .res_mismatch(ma), .res_dropped(da)
  );

  video_frame_probe #(.CNTW(4)) u_sat (
    .video_clk_pix(clk), .rst(rst), .video_enable(video_enable),
    .frame_start(frame_start), .line_start(line_start),
    .red(red), .green(green), .blue(blue),
    .res_valid(vb), .res_ready(res_ready), .res_width(wb), .res_height(hb),
    .res_lit(lb), .res_luma(sb), .res_mismatch(mb), .res_dropped(db)
  );

  typedef struct {
    int unsigned     width_a, height_a, width_b, height_b;
    bit              mis_a, mis_b;
    longint unsigned lit, luma;
    int unsigned     dropped;
  } exp_t;

  exp_t            q[$];
  int unsigned     lines[$];
  int unsigned     lens[$];
  longint unsigned cur_lit, cur_luma;
  bit              m_measure, m_valid;
  int unsigned     m_dropped;
  int              n_checks = 0;
  int              n_pass   = 0;

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Frame geometry from the list of per-line active pixel counts
  function automatic void line_stats(input int unsigned cntw, output int unsigned w,
                                     output int unsigned h, output bit mis);
    int unsigned maxv, l;
    bit have;
    maxv = (1 << cntw) - 1;
    have = 0; w = 0; h = 0; mis = 0;
    foreach (lines[i]) begin
      l = (lines[i] > maxv) ? maxv : lines[i];
      if (l != 0) begin
        if (h < maxv) h++;
        if (!have) begin w = l; have = 1; end
        else if (l != w) mis = 1;
      end
    end
  endfunction

  function automatic exp_t frame_expect();
    exp_t e;
    line_stats(12, e.width_a, e.height_a, e.mis_a);
    line_stats(4,  e.width_b, e.height_b, e.mis_b);
    e.lit     = (cur_lit  > 64'hFF_FFFF)    ? 64'hFF_FFFF    : cur_lit;
    e.luma    = (cur_luma > 64'hFFFF_FFFF)  ? 64'hFFFF_FFFF  : cur_luma;
    e.dropped = 0;
    return e;
  endfunction

  // One pixel clock of stimulus plus the frame/handshake model update
  task automatic step(input bit fs, input bit ls, input bit en,
                      input logic [9:0] r, input logic [9:0] g, input logic [9:0] b, input bit rdy);
    bit   nv, pub;
    exp_t e;
    frame_start = fs; line_start = ls; video_enable = en;
    red = r; green = g; blue = b; res_ready = rdy;
    nv = m_valid; pub = 0;
    if (fs) begin
      if (m_measure) begin
        e = frame_expect();
        if (m_valid && !rdy) begin
          void'(q.pop_back());
          if (m_dropped < 255) m_dropped++;
        end
        e.dropped = m_dropped;
        q.push_back(e);
        pub = 1;
      end
      m_measure = 1;
      lines.delete();
      lines.push_back(0);
      cur_lit = 0;
      cur_luma = 0;
    end else if (ls && m_measure) begin
      lines.push_back(0);
    end
    if (pub) nv = 1;
    else if (m_valid && rdy) nv = 0;
    if (en && m_measure) begin
      lines[lines.size()-1] = lines[lines.size()-1] + 1;
      if (r >= 10'd128 || g >= 10'd128 || b >= 10'd128) cur_lit++;
      cur_luma += longint'((int'(r) + 2 * int'(g) + int'(b)) / 4);
    end
    @(posedge clk);
    #1;
    m_valid = nv;
  endtask

  // rmode: 0 ready low, 1 ready high, 2 random; fs_rdy drives the frame_start cycle
  task automatic send_frame(input int unsigned fl[$], input bit rnd_col,
                            input logic [9:0] cr, input logic [9:0] cg, input logic [9:0] cb,
                            input int rmode, input bit fs_rdy, input bit rnd_gap);
    int unsigned lead, trail, total;
    bit          fs, ls, en, rdy;
    logic [9:0]  r, g, b;
    foreach (fl[i]) begin
      lead  = rnd_gap ? $urandom_range(0, 2) : 1;
      trail = rnd_gap ? $urandom_range(1, 3) : 2;
      total = lead + fl[i] + trail;
      for (int c = 0; c < int'(total); c++) begin
        fs = (c == 0) && (i == 0);
        ls = (c == 0) && ((i != 0) || (rnd_gap && ($urandom_range(0, 1) == 1)));
        en = (c >= int'(lead)) && (c < int'(lead + fl[i]));
        if (rnd_col) begin
          r = 10'($urandom_range(0, 1023));
          g = 10'($urandom_range(0, 1023));
          b = 10'($urandom_range(0, 1023));
        end else begin
          r = cr; g = cg; b = cb;
        end
        if (fs) rdy = fs_rdy;
        else if (rmode == 2) rdy = ($urandom_range(0, 1) == 1);
        else rdy = (rmode == 1);
        step(fs, ls, en, r, g, b, rdy);
      end
    end
  endtask

  task automatic set_uniform(input int unsigned n, input int unsigned len);
    lens.delete();
    for (int i = 0; i < int'(n); i++) lens.push_back(len);
  endtask

  task automatic check_zero();
    check("rst_valid_a", va, 0);    check("rst_valid_b", vb, 0);
    check("rst_width_a", wa, 0);    check("rst_width_b", wb, 0);
    check("rst_height_a", ha, 0);   check("rst_height_b", hb, 0);
    check("rst_lit_a", la, 0);      check("rst_luma_a", sa, 0);
    check("rst_mis_a", ma, 0);      check("rst_dropped_a", da, 0);
    check("rst_dropped_b", db, 0);
  endtask

  // Monitor: per-cycle valid check, and result compare on acceptance
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      check("valid_a", va, m_valid);
      check("valid_b", vb, m_valid);
      if (va && res_ready) begin
        check("result_expected", q.size() > 0, 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          check("width_a", wa, e.width_a);
          check("height_a", ha, e.height_a);
          check("lit_a", la, e.lit);
          check("luma_a", sa, e.luma);
          check("mismatch_a", ma, e.mis_a);
          check("dropped_a", da, e.dropped);
          check("width_b", wb, e.width_b);
          check("height_b", hb, e.height_b);
          check("mismatch_b", mb, e.mis_b);
          check("lit_b", lb, e.lit);
          check("luma_b", sb, e.luma);
          check("dropped_b", db, e.dropped);
        end
      end
    end
  end

  initial begin
    int unsigned nl, base;
    rst = 1'b1;
    frame_start = 0; line_start = 0; video_enable = 0; res_ready = 0;
    red = '0; green = '0; blue = '0;
    m_measure = 0; m_valid = 0; m_dropped = 0; cur_lit = 0; cur_luma = 0;
    repeat (2) @(posedge clk);
    #1;
    check_zero();
    rst = 1'b0;

    // 4x8 bright frames with ready low: one publish, then three drops
    set_uniform(4, 8);
    for (int f = 0; f < 5; f++) send_frame(lens, 0, 10'd200, 10'd200, 10'd200, 0, 0, 0);
    step(0, 0, 0, '0, '0, '0, 1);
    step(0, 0, 0, '0, '0, '0, 0);

    // Mismatching line widths; its fs publishes the last bright frame
    lens.delete();
    lens.push_back(8); lens.push_back(8); lens.push_back(7); lens.push_back(8);
    send_frame(lens, 0, 10'd100, 10'd0, 10'd129, 0, 0, 0);

    // Publish coincident with ready while valid; 20-px lines saturate CNTW=4
    set_uniform(17, 20);
    send_frame(lens, 0, 10'd200, 10'd200, 10'd200, 1, 1, 0);

    // Randomized frames
    for (int f = 0; f < 12; f++) begin
      nl   = $urandom_range(1, 6);
      base = $urandom_range(0, 12);
      lens.delete();
      for (int l = 0; l < int'(nl); l++)
        lens.push_back(($urandom_range(0, 3) == 0) ? $urandom_range(0, 12) : base);
      send_frame(lens, 1, '0, '0, '0, 2, ($urandom_range(0, 1) == 1), 1);
    end

    // Mid-frame asynchronous reset with a pending result
    set_uniform(3, 6);
    send_frame(lens, 1, '0, '0, '0, 0, 0, 1);
    frame_start = 0; line_start = 0; video_enable = 0; res_ready = 0;
    #2;
    rst = 1'b1;
    #1;
    check_zero();
    q.delete(); lines.delete();
    m_valid = 0; m_dropped = 0; m_measure = 0; cur_lit = 0; cur_luma = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // First fs after release opens a frame, second publishes it
    set_uniform(3, 5);
    send_frame(lens, 0, 10'd300, 10'd10, 10'd10, 0, 0, 0);
    send_frame(lens, 1, '0, '0, '0, 0, 0, 0);
    send_frame(lens, 1, '0, '0, '0, 2, 0, 1);
    repeat (3) step(0, 0, 0, '0, '0, '0, 1);
    check("queue_drained", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
